// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_tx serial transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Widest word the parity helper accepts; narrower words are zero-extended.
  localparam int MAX_W = 64;

  function automatic logic even_parity(input logic [MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: cleared on load, advances on enable, flags the last bit.
module piso_bit_counter #(
  parameter  int FL = 8,
  localparam int CW = $clog2(FL + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          last
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || load) r_count <= '0;
    else if (enable)   r_count <= r_count + 1'b1;
  end

  assign count = r_count;
  assign last  = (r_count == CW'(FL - 1));

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready input handshake.
// Define PISO_TX_PARITY_EN to append an even-parity bit after each word.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             done
);

`ifdef PISO_TX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = $clog2(FL + 1);

  state_t          r_state, w_next;
  logic [FL-1:0]   r_shreg;
  logic [FL-1:0]   w_frame;
  logic [WIDTH-1:0] w_ord;
  logic [CW-1:0]   w_count;
  logic            w_last, w_busy, w_accept;

  assign w_busy    = (r_state == SHIFT);
  assign din_ready = !reset && (!w_busy || w_last);
  assign w_accept  = din_valid && din_ready;

  // Reorder so the first bit to send always sits at the top of the frame.
  always_comb begin
    w_ord = '0;
    for (int i = 0; i < WIDTH; i++)
      w_ord[i] = MSB_FIRST ? din[i] : din[WIDTH-1-i];
  end

`ifdef PISO_TX_PARITY_EN
  assign w_frame = {w_ord, even_parity(MAX_W'(din))};
`else
  assign w_frame = w_ord;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SHIFT;
      SHIFT:   if (w_last && !w_accept) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Zeros shift in from the bottom, so the register drains to 0 by frame end
  // and so reads 0 whenever no frame bit is on the line.
  always_ff @(posedge clk) begin
    if (reset)         r_shreg <= '0;
    else if (w_accept) r_shreg <= w_frame;
    else if (w_busy)   r_shreg <= {r_shreg[FL-2:0], 1'b0};
  end

  piso_bit_counter #(.FL(FL)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (w_accept || (w_busy && w_last)),
    .enable (w_busy),
    .count  (w_count),
    .last   (w_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) assert (w_count <= CW'(FL - 1));
  end

  assign so       = r_shreg[FL-1];
  assign so_valid = w_busy;
  assign busy     = w_busy;
  assign done     = w_busy && w_last;

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: MSB-first and LSB-first instances side by side.
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din0 = '0, din1 = '0;
  logic       vld0 = 1'b0, vld1 = 1'b0;
  logic       rdy0, so0, sv0, busy0, done0;
  logic       rdy1, so1, sv1, busy1, done1;

  int errs = 0;
  int checks = 0;

  typedef struct {bit b; bit last;} exp_t;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .reset(reset), .din(din0), .din_valid(vld0), .din_ready(rdy0),
    .so(so0), .so_valid(sv0), .busy(busy0), .done(done0)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .reset(reset), .din(din1), .din_valid(vld1), .din_ready(rdy1),
    .so(so1), .so_valid(sv1), .busy(busy1), .done(done1)
  );

  task automatic push_word(input logic [7:0] w, input bit msb, input bit lane);
    exp_t e;
    for (int i = 0; i < FL; i++) begin
      if (i < 8) e.b = msb ? w[7-i] : w[i];
      else       e.b = ^w;
      e.last = (i == FL - 1);
      if (lane) q1.push_back(e);
      else      q0.push_back(e);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({so0, sv0, busy0, done0, rdy0} !== 5'b0) begin
      errs++; $display("FAIL reset_outs0: got %b want 00000", {so0, sv0, busy0, done0, rdy0});
    end
    checks++;
    if ({so1, sv1, busy1, done1, rdy1} !== 5'b0) begin
      errs++; $display("FAIL reset_outs1: got %b want 00000", {so1, sv1, busy1, done1, rdy1});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({rdy0, rdy1} !== 2'b11) begin
      errs++; $display("FAIL reset_release_rdy: got %b want 11", {rdy0, rdy1});
    end
  endtask

  task automatic test_msb_first(input logic [7:0] w);
    exp_t e;
    din0 = w; vld0 = 1'b1;
    push_word(w, 1'b1, 1'b0);
    for (int c = 0; c < FL + 2; c++) begin
      @(negedge clk);
      if (c == 0) vld0 = 1'b0;
      checks++;
      if (sv0 !== logic'(c < FL)) begin
        errs++; $display("FAIL msb_valid c=%0d: got %b want %b", c, sv0, c < FL);
      end
      if (sv0 === 1'b1 && q0.size() > 0) begin
        e = q0.pop_front();
        checks++;
        if ({so0, done0, rdy0} !== {e.b, e.last, e.last}) begin
          errs++; $display("FAIL msb_bit c=%0d: so/done/rdy got %b want %b", c, {so0, done0, rdy0}, {e.b, e.last, e.last});
        end
      end else begin
        checks++;
        if ({so0, done0, busy0} !== 3'b0) begin
          errs++; $display("FAIL msb_idle c=%0d: so/done/busy got %b want 000", c, {so0, done0, busy0});
        end
      end
    end
    checks++;
    if (q0.size() != 0) begin
      errs++; $display("FAIL msb_left: got %0d bits pending want 0", q0.size());
    end
    q0.delete();
  endtask

  task automatic test_lsb_first(input logic [7:0] w);
    exp_t e;
    din1 = w; vld1 = 1'b1;
    push_word(w, 1'b0, 1'b1);
    for (int c = 0; c < FL + 2; c++) begin
      @(negedge clk);
      if (c == 0) vld1 = 1'b0;
      checks++;
      if (busy1 !== logic'(c < FL)) begin
        errs++; $display("FAIL lsb_busy c=%0d: got %b want %b", c, busy1, c < FL);
      end
      if (sv1 === 1'b1 && q1.size() > 0) begin
        e = q1.pop_front();
        checks++;
        if ({so1, done1} !== {e.b, e.last}) begin
          errs++; $display("FAIL lsb_bit c=%0d: so/done got %b want %b", c, {so1, done1}, {e.b, e.last});
        end
      end else begin
        checks++;
        if ({so1, sv1, done1} !== 3'b0) begin
          errs++; $display("FAIL lsb_idle c=%0d: so/valid/done got %b want 000", c, {so1, sv1, done1});
        end
      end
    end
    checks++;
    if (q1.size() != 0) begin
      errs++; $display("FAIL lsb_left: got %0d bits pending want 0", q1.size());
    end
    q1.delete();
  endtask

  task automatic test_back_to_back;
    exp_t e;
    bit pend;
    int n;
    din0 = 8'hA5; vld0 = 1'b1;
    push_word(8'hA5, 1'b1, 1'b0);
    pend = 1'b1; n = 1;
    for (int c = 0; c < 2*FL + 2; c++) begin
      @(negedge clk);
      checks++;
      if (sv0 !== logic'(c < 2*FL)) begin
        errs++; $display("FAIL b2b_valid c=%0d: got %b want %b", c, sv0, c < 2*FL);
      end
      if (sv0 === 1'b1 && q0.size() > 0) begin
        e = q0.pop_front();
        checks++;
        if ({so0, done0} !== {e.b, e.last}) begin
          errs++; $display("FAIL b2b_bit c=%0d: so/done got %b want %b", c, {so0, done0}, {e.b, e.last});
        end
      end
      if (pend) begin
        pend = 1'b0;
        if (n < 2) din0 = 8'h3C;
        else       vld0 = 1'b0;
      end
      if (vld0 && rdy0) begin
        checks++;
        if (c != FL - 1) begin
          errs++; $display("FAIL b2b_accept: got cycle %0d want %0d", c, FL - 1);
        end
        push_word(din0, 1'b1, 1'b0);
        pend = 1'b1; n++;
      end
    end
    checks++;
    if (q0.size() != 0) begin
      errs++; $display("FAIL b2b_left: got %0d bits pending want 0", q0.size());
    end
    q0.delete();
  endtask

  task automatic test_backpressure;
    exp_t e;
    bit pend;
    din0 = 8'hA5; vld0 = 1'b1;
    push_word(8'hA5, 1'b1, 1'b0);
    pend = 1'b1;
    for (int c = 0; c < 2*FL + 2; c++) begin
      @(negedge clk);
      checks++;
      if (sv0 !== logic'(c < 2*FL)) begin
        errs++; $display("FAIL bp_valid c=%0d: got %b want %b", c, sv0, c < 2*FL);
      end
      if (sv0 === 1'b1 && q0.size() > 0) begin
        e = q0.pop_front();
        checks++;
        if ({so0, done0} !== {e.b, e.last}) begin
          errs++; $display("FAIL bp_bit c=%0d: so/done got %b want %b", c, {so0, done0}, {e.b, e.last});
        end
      end
      if (pend) begin pend = 1'b0; vld0 = 1'b0; end
      if (c == 2) begin
        din0 = 8'hFF; vld0 = 1'b1;
        checks++;
        if (rdy0 !== 1'b0) begin
          errs++; $display("FAIL bp_rdy_mid: got %b want 0", rdy0);
        end
      end
      if (vld0 && rdy0) begin
        checks++;
        if (c != FL - 1) begin
          errs++; $display("FAIL bp_accept: got cycle %0d want %0d", c, FL - 1);
        end
        push_word(din0, 1'b1, 1'b0);
        pend = 1'b1;
      end
    end
    checks++;
    if (q0.size() != 0) begin
      errs++; $display("FAIL bp_left: got %0d bits pending want 0", q0.size());
    end
    q0.delete();
  endtask

  task automatic test_reset_mid;
    logic [7:0] w;
    int n;
    w = 8'hA5;
    din0 = w; vld0 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) vld0 = 1'b0;
      checks++;
      if ({sv0, so0} !== {1'b1, w[7-c]}) begin
        errs++; $display("FAIL rstmid_bit c=%0d: valid/so got %b want %b", c, {sv0, so0}, {1'b1, w[7-c]});
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({so0, sv0, busy0, done0, rdy0} !== 5'b0) begin
      errs++; $display("FAIL rstmid_outs: got %b want 00000", {so0, sv0, busy0, done0, rdy0});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1) begin
      errs++; $display("FAIL rstmid_rdy: got %b want 1", rdy0);
    end
    n = 0;
    repeat (FL + 2) begin
      @(negedge clk);
      if (sv0 !== 1'b0 || so0 !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      errs++; $display("FAIL rstmid_residual: got %0d active cycles want 0", n);
    end
  endtask

`ifdef PISO_TX_PARITY_EN
  task automatic test_parity(input logic [7:0] w, input bit par);
    din0 = w; vld0 = 1'b1;
    for (int c = 0; c < FL + 1; c++) begin
      @(negedge clk);
      if (c == 0) vld0 = 1'b0;
      if (c == FL - 1) begin
        checks++;
        if ({sv0, so0, done0} !== {1'b1, par, 1'b1}) begin
          errs++; $display("FAIL parity_%h: valid/so/done got %b want %b", w, {sv0, so0, done0}, {1'b1, par, 1'b1});
        end
      end
    end
  endtask
`endif

  task automatic test_random;
    exp_t e;
    bit pend;
    int sent;
    pend = 1'b0; sent = 0;
    for (int c = 0; c < 800 && !(sent == 24 && q0.size() == 0 && !vld0); c++) begin
      @(negedge clk);
      if (sv0 === 1'b1) begin
        checks++;
        if (q0.size() == 0) begin
          errs++; $display("FAIL rand_extra c=%0d: got unexpected bit want none", c);
        end else begin
          e = q0.pop_front();
          if ({so0, done0, rdy0} !== {e.b, e.last, e.last}) begin
            errs++; $display("FAIL rand_bit c=%0d: so/done/rdy got %b want %b", c, {so0, done0, rdy0}, {e.b, e.last, e.last});
          end
        end
      end
      if (pend) begin pend = 1'b0; vld0 = 1'b0; end
      if (!vld0 && sent < 24 && $urandom_range(0, 3) != 0) begin
        din0 = 8'($urandom); vld0 = 1'b1;
      end
      if (vld0 && rdy0) begin
        push_word(din0, 1'b1, 1'b0);
        pend = 1'b1; sent++;
      end
    end
    checks++;
    if (q0.size() != 0 || sent != 24) begin
      errs++; $display("FAIL rand_drain: got sent=%0d pending=%0d want 24/0", sent, q0.size());
    end
    q0.delete();
  endtask

  initial begin
    test_reset();
    test_msb_first(8'hA5);
    test_msb_first(8'h07);
    test_lsb_first(8'h01);
    test_lsb_first(8'hC2);
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef PISO_TX_PARITY_EN
    test_parity(8'hA5, 1'b0);
    test_parity(8'h07, 1'b1);
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter that generates the serial bit stream consumed by the team's serial shift-register blocks. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on `so`, with `so_valid` qualifying each bit. Back-to-back words are sent with no idle gap. It sits between a parallel producer and any serial-in register chain.

## Interface
- WIDTH, 8, data word width in bits (≥2)
- MSB_FIRST, 1, 1 = din[WIDTH-1] sent first; 0 = din[0] sent first

- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- din  input  WIDTH  parallel word to transmit
- din_valid  input  1  producer has a word on din
- din_ready  output  1  transmitter will accept din this cycle
- so  output  1  serial data out, registered
- so_valid  output  1  so carries a frame bit this cycle
- busy  output  1  a frame is in progress
- done  output  1  one-cycle pulse coinciding with the last bit of a frame

## Operation
- States: IDLE, SHIFT.
- Frame length FL = WIDTH (WIDTH+1 with parity, see Configuration).
- Accept = din_valid && din_ready, sampled at a rising edge.
- din_ready = 1 in IDLE, or in SHIFT when the current bit is the last bit of the frame; 0 otherwise. Forced 0 while reset is high.
- IDLE + accept → SHIFT: load shift register from din, bit counter = 0.
- SHIFT: each edge advances one bit, counter += 1. At the last bit: accept → reload, counter = 0, stay in SHIFT; no accept → IDLE.
- Counter width $clog2(FL+1); counter never exceeds FL-1.
- so = 0 whenever so_valid = 0.
- busy = (state == SHIFT). done = so_valid && last bit.
- din is sampled only at accept; later changes to din do not affect the frame in flight.

## Timing
- Reset values: so=0, so_valid=0, busy=0, done=0, state=IDLE, counter=0. din_ready=0 during reset, 1 on the first cycle after release.
- Latency: word accepted at edge N → first bit on so during cycle N+1; last data bit during cycle N+FL.
- Throughput: one bit per clock; continuous din_valid gives unbroken so_valid.
- Reset mid-frame: remaining bits are discarded; so and so_valid are 0 from the next edge on.
- din_valid while din_ready=0: ignored; the producer must hold din and din_valid until accepted.

## Configuration
- PISO_TX_PARITY_EN defined: FL = WIDTH+1. After the data bits, one even-parity bit (XOR of all din bits) is sent. done and din_ready track the parity bit as the last bit.
- PISO_TX_PARITY_EN not defined: FL = WIDTH. No parity logic is generated.

## Structure
- Package piso_pkg: state_t enum {IDLE, SHIFT}; even-parity function.
- Sub-module piso_bit_counter:
  - Inputs: load, enable.
  - Outputs: count, last (count == FL-1).
  - FL is passed in as a parameter.
- Shift register, FSM and handshake logic live in piso_tx.

## Test plan
- WIDTH=8, MSB_FIRST=1, din=8'hA5 accepted → so = 1,0,1,0,0,1,0,1 on 8 consecutive so_valid cycles; done high on the 8th only; din_ready returns to 1 on the 8th.
- MSB_FIRST=0, din=8'h01 → so = 1 then seven 0s; busy falls the cycle after done.
- Back-to-back: 8'hA5 then 8'h3C with din_valid held → 16 contiguous so_valid cycles, second word accepted on the last bit of the first, no gap.
- Backpressure: din_valid raised with 8'hFF during the 3rd bit of a frame → not accepted until the last bit; 8'hFF then follows immediately.
- Reset asserted after 3 bits of 8'hA5 → so=0 and so_valid=0 from the next edge; din_ready=1 after release; no residual bits.
- PISO_TX_PARITY_EN, din=8'hA5 → 9th bit 0; din=8'h07 → 9th bit 1; done on the 9th bit.
